// File: rtl/nb_dispatch_scheduler_pkg.sv
// Shared types and widths for the neighbour dispatch scheduler.
// Holds the arbitration-mode enum and the default neighbour entry width.
package MD_pkg;

    typedef enum logic {
        DISPATCH_ARB_RR    = 1'b0,
        DISPATCH_ARB_FIXED = 1'b1
    } dispatch_arb_mode_t;

    localparam int POS_PKT_STRUCT_WIDTH = 96;
    localparam int NODE_ID_WIDTH        = 9;
    localparam int DEFAULT_DATA_W       = POS_PKT_STRUCT_WIDTH + NODE_ID_WIDTH;

endpackage

// File: rtl/nb_dispatch_scheduler_arbiter.sv
// One-hot grant arbiter over the filter channels, round-robin or fixed priority.
// Owns the round-robin pointer, which advances only when a grant is issued.
module dispatch_arbiter
    import MD_pkg::*;
#(
    parameter int                 NUM_FILTERS = 8,
    parameter dispatch_arb_mode_t ARB_MODE    = DISPATCH_ARB_RR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_FILTERS-1:0] request,
    input  logic                   enable,
    output logic [NUM_FILTERS-1:0] grant
);

    localparam int PW = $clog2(NUM_FILTERS);

    logic [PW-1:0]            ptr_q;
    logic [PW-1:0]            ptr_d;
    logic [PW-1:0]            start;
    logic [NUM_FILTERS-1:0]   maskedReq;
    logic [NUM_FILTERS-1:0]   rotReq;
    logic [NUM_FILTERS-1:0]   rotGnt;
    logic [2*NUM_FILTERS-1:0] dblReq;
    logic [2*NUM_FILTERS-1:0] dblGnt;

    // Rotate requests so the search start sits at bit 0, pick the lowest set bit, rotate back.
    always_comb begin
        start = '0;
        if (ARB_MODE == DISPATCH_ARB_RR) begin
            start = (ptr_q == PW'(NUM_FILTERS - 1)) ? '0 : ptr_q + PW'(1);
        end
        maskedReq = enable ? request : '0;
        dblReq    = {maskedReq, maskedReq} >> start;
        rotReq    = dblReq[NUM_FILTERS-1:0];
        rotGnt    = rotReq & (~rotReq + NUM_FILTERS'(1));
        dblGnt    = {rotGnt, rotGnt} << start;
        grant     = dblGnt[2*NUM_FILTERS-1:NUM_FILTERS];
    end

    always_comb begin
        ptr_d = ptr_q;
        for (int i = 0; i < NUM_FILTERS; i++) begin
            if (grant[i]) begin
                ptr_d = PW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= PW'(NUM_FILTERS - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/nb_dispatch_scheduler.sv
// Buffers incoming neighbour entries and hands each one to a single eligible filter.
// Grants are registered onto a shared data bus with a per-filter cooldown after each grant.
module nb_dispatch_scheduler
    import MD_pkg::*;
#(
    parameter int                 NUM_FILTERS = 8,
    parameter int                 DATA_W      = DEFAULT_DATA_W,
    parameter int                 FIFO_DEPTH  = 16,
    parameter int                 COOLDOWN    = 2,
    parameter dispatch_arb_mode_t ARB_MODE    = DISPATCH_ARB_RR,
    parameter int                 BP_THRESH   = FIFO_DEPTH - 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_spin_en,
    input  logic                            i_flush,
    input  logic [DATA_W-1:0]               i_data,
    input  logic                            i_data_valid,
    output logic                            o_data_ready,
    output logic                            o_back_pressure,
    input  logic [NUM_FILTERS-1:0]          i_filter_request,
    input  logic [NUM_FILTERS-1:0]          i_filter_back_pressure,
    output logic [DATA_W-1:0]               o_dispatch_data,
    output logic [NUM_FILTERS-1:0]          o_dispatch_valid,
    output logic                            o_buffer_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] o_occupancy,
    output logic [31:0]                     o_dispatch_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = $clog2(FIFO_DEPTH + 1);
    localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    logic [DATA_W-1:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_q;
    logic [AW-1:0]          rd_q;
    logic [OW-1:0]          occ_q;
    logic [CW-1:0]          cool_q [NUM_FILTERS];
    logic [NUM_FILTERS-1:0] valid_q;
    logic [DATA_W-1:0]      data_q;
    logic [31:0]            count_q;

    logic                   push;
    logic                   pop;
    logic                   arbEnable;
    logic [NUM_FILTERS-1:0] eligible;
    logic [NUM_FILTERS-1:0] grant;

    assign o_data_ready     = (occ_q != OW'(FIFO_DEPTH));
    assign o_back_pressure  = (occ_q >= OW'(BP_THRESH));
    assign o_buffer_empty   = (occ_q == '0);
    assign o_occupancy      = occ_q;
    assign o_dispatch_valid = valid_q;
    assign o_dispatch_data  = data_q;
    assign o_dispatch_count = count_q;

    assign push      = i_data_valid & o_data_ready & ~i_flush;
    assign arbEnable = i_spin_en & ~o_buffer_empty & ~i_flush;
    assign pop       = |grant;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_FILTERS; i++) begin
            eligible[i] = i_filter_request[i] & ~i_filter_back_pressure[i] & (cool_q[i] == '0);
        end
    end

    dispatch_arbiter #(
        .NUM_FILTERS (NUM_FILTERS),
        .ARB_MODE    (ARB_MODE)
    ) u_arbiter (
        .clk     (clk),
        .rst     (rst),
        .request (eligible),
        .enable  (arbEnable),
        .grant   (grant)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= i_data;
        end
    end

    // A flush realigns both pointers so stale entries can never resurface.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else if (i_flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
            if (push && !pop)      occ_q <= occ_q + OW'(1);
            else if (pop && !push) occ_q <= occ_q - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_FILTERS; i++) cool_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_FILTERS; i++) begin
                if (i_flush)               cool_q[i] <= '0;
                else if (grant[i])         cool_q[i] <= CW'(COOLDOWN);
                else if (cool_q[i] != '0)  cool_q[i] <= cool_q[i] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= grant;
            if (pop) begin
                data_q <= mem_q[rd_q];
                if (count_q != '1) count_q <= count_q + 32'd1;
            end
        end
    end

endmodule

// File: doc/nb_dispatch_scheduler.md
NB_DISPATCH_SCHEDULER -- requirements
Module: nb_dispatch_scheduler

Interface
REQ-001 Parameter NUM_FILTERS, default 8, number of filter channels (2..32).
REQ-002 Parameter DATA_W, default POS_PKT_STRUCT_WIDTH+NODE_ID_WIDTH, width of one neighbour entry (pos packet + node id).
REQ-003 Parameter FIFO_DEPTH, default 16, entries in the dispatch buffer (power of 2, >=4).
REQ-004 Parameter COOLDOWN, default 2, idle cycles a filter stays ineligible after a grant (0 = none).
REQ-005 Parameter ARB_MODE, default DISPATCH_ARB_RR, selects round-robin (RR) or fixed lowest-index priority (FIXED).
REQ-006 Parameter BP_THRESH, default FIFO_DEPTH-4, occupancy at which back pressure asserts.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-low.
REQ-009 i_spin_en  in  1  dispatch permitted (position spinning phase).
REQ-010 i_flush  in  1  synchronous buffer clear.
REQ-011 i_data  in  DATA_W  incoming neighbour entry.
REQ-012 i_data_valid  in  1  i_data present.
REQ-013 o_data_ready  out  1  buffer not full.
REQ-014 o_back_pressure  out  1  occupancy >= BP_THRESH.
REQ-015 i_filter_request  in  NUM_FILTERS  filter has free nb slot.
REQ-016 i_filter_back_pressure  in  NUM_FILTERS  filter refuses input.
REQ-017 o_dispatch_data  out  DATA_W  entry sent to the granted filter (shared bus).
REQ-018 o_dispatch_valid  out  NUM_FILTERS  one-hot grant, qualifies o_dispatch_data.
REQ-019 o_buffer_empty  out  1  buffer holds no entries.
REQ-020 o_occupancy  out  $clog2(FIFO_DEPTH+1)  current entry count.
REQ-021 o_dispatch_count  out  32  total grants since reset.

Function
REQ-022 Push occurs when i_data_valid & o_data_ready & ~i_flush; o_data_ready = (occupancy != FIFO_DEPTH), combinational from registered occupancy only.
REQ-023 A pushed entry becomes eligible for dispatch the following cycle (no write-through).
REQ-024 eligible[i] = i_filter_request[i] & ~i_filter_back_pressure[i] & (cooldown[i]==0).
REQ-025 Grant occurs in cycle t when i_spin_en & ~o_buffer_empty & ~i_flush & |eligible; exactly one filter granted, head entry popped.
REQ-026 o_dispatch_valid and o_dispatch_data are registered: grant at t appears at t+1 for exactly one cycle; o_dispatch_data holds last value when no grant.
REQ-027 RR mode: search starts at (last_granted+1) mod NUM_FILTERS, wraps; pointer updates only on grant; FIXED mode: lowest eligible index.
REQ-028 On grant to filter i, cooldown[i] loads COOLDOWN and decrements by 1 per cycle to 0; filter i earliest re-grant is t+COOLDOWN+1.
REQ-029 Simultaneous push and pop: occupancy unchanged; push at full never occurs, even if a pop happens that cycle.
REQ-030 i_flush: occupancy to 0, read/write pointers equalised, all cooldowns to 0, no grant, concurrent write dropped; RR pointer and o_dispatch_count retained.
REQ-031 o_dispatch_count increments by 1 per grant, saturates at 2^32-1.
REQ-032 Deasserting i_spin_en holds buffer contents; no entry is lost or duplicated.

Reset
REQ-033 While rst low: o_dispatch_valid=0, o_dispatch_data=0, o_occupancy=0, o_buffer_empty=1, o_data_ready=1, o_back_pressure=0, o_dispatch_count=0, cooldowns=0, RR pointer=NUM_FILTERS-1 (first search starts at filter 0).
REQ-034 Reset asserted mid-operation discards all buffered entries; first grant after release follows REQ-025 from the cleared state.

Structure
REQ-035 dispatch_arb_mode_t enum (DISPATCH_ARB_RR, DISPATCH_ARB_FIXED) and default DATA_W constant live in MD_pkg.
REQ-036 Arbitration is one sub-module, dispatch_arbiter (parameters NUM_FILTERS, ARB_MODE; inputs request, enable; output one-hot grant; owns the RR pointer); buffer storage is an inline register array.

Verification
REQ-037 NUM_FILTERS=4, COOLDOWN=2, RR, all requests high, 8 entries pushed, spin on -> grants 0,1,2,3,0,1,2,3 on consecutive cycles, data in push order.
REQ-038 NUM_FILTERS=4, COOLDOWN=2, only filter 2 requesting, 3 entries -> o_dispatch_valid=4'b0100 at t+1, t+4, t+7.
REQ-039 FIXED mode, filters 1 and 3 eligible every cycle, COOLDOWN=0 -> every grant to filter 1.
REQ-040 FIFO_DEPTH=16, spin off, 17 valid writes -> 16 accepted, o_data_ready=0 after 16th, o_back_pressure=1 from occupancy 12.
REQ-041 Occupancy 5 with i_flush and i_data_valid high same cycle -> next cycle occupancy 0, o_buffer_empty=1, no dispatch, count unchanged.
REQ-042 Assert rst during active dispatch -> all outputs at REQ-033 values immediately, without a clock edge.
